// File: rtl/fp_to_int.sv
// fp_to_int: binary32 to integer converter with trunc/RNE rounding, saturation and an LATENCY-deep enable-gated pipeline.
module fp_to_int #(
  parameter int OUT_WIDTH = 32,
  parameter int LATENCY   = 3
) (
  input  logic                 clk,
  input  logic                 areset,
  input  logic                 en,
  input  logic                 in_valid,
  input  logic [31:0]          a,
  input  logic                 is_signed,
  input  logic                 rnd,
  output logic                 out_valid,
  output logic [OUT_WIDTH-1:0] q,
  output logic                 invalid,
  output logic                 inexact
);
  localparam int FW = OUT_WIDTH + 25;
  localparam int MW = OUT_WIDTH + 2;
  localparam int DW = OUT_WIDTH + 2;
  logic                 sgn;
  logic [7:0]           ex;
  logic [22:0]          man;
  logic                 is_nan, is_denorm, huge, tiny, g, st, up, rng;
  logic [7:0]           sh;
  logic [FW-1:0]        fx;
  logic [OUT_WIDTH:0]   ip;
  logic [MW-1:0]        mag, lim;
  logic [OUT_WIDTH-1:0] qmax, qmin, cq;
  logic                 cinv, cinx;
  logic [LATENCY-1:0]   v;
  logic [DW-1:0]        d [LATENCY];
  assign {sgn, ex, man} = a;
  // fx holds |a| * 2^24: integer part above bit 24, guard at bit 23, sticky below.
  // Exponents too small to reach 0.5 wrap sh past FW, so fx and ip collapse to zero.
  always_comb begin
    is_nan    = (&ex) & (|man);
    is_denorm = ~|ex;
    huge      = ex >= 8'(OUT_WIDTH + 128);
    tiny      = ex < 8'd126;
    sh        = ex - 8'd126;
    fx        = FW'({1'b1, man}) << sh;
    ip        = fx[FW-1:24];
    g         = tiny ? 1'b0 : fx[23];
    st        = tiny ? 1'b1 : |fx[22:0];
    up        = rnd & g & (st | ip[0]);
    mag       = MW'(ip) + MW'(up);
    lim       = is_signed ? (sgn ? {3'b001, {(OUT_WIDTH-1){1'b0}}} : {3'b000, {(OUT_WIDTH-1){1'b1}}})
                          : (sgn ? '0 : {2'b00, {OUT_WIDTH{1'b1}}});
    rng       = huge | (mag > lim);
    qmax      = is_signed ? {1'b0, {(OUT_WIDTH-1){1'b1}}} : '1;
    qmin      = is_signed ? {1'b1, {(OUT_WIDTH-1){1'b0}}} : '0;
    cinv      = is_nan | rng;
    cq        = is_nan ? qmax : rng ? (sgn ? qmin : qmax)
              : (sgn ? -mag[OUT_WIDTH-1:0] : mag[OUT_WIDTH-1:0]);
    cinx      = ~cinv & (is_denorm ? |man : (g | st));
  end
  // Data stages load only behind a valid token so outputs stay zero until the first result.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      v <= '0;
      for (int i = 0; i < LATENCY; i++) d[i] <= '0;
    end else if (en) begin
      v[0] <= in_valid;
      if (in_valid) d[0] <= {cq, cinv, cinx};
      for (int i = 1; i < LATENCY; i++) begin
        v[i] <= v[i-1];
        if (v[i-1]) d[i] <= d[i-1];
      end
    end
  end
  assign out_valid = v[LATENCY-1];
  assign {q, invalid, inexact} = d[LATENCY-1];
endmodule

// File: tb/tb_fp_to_int.sv
// tb_fp_to_int: directed and random checks of two fp_to_int instances against an exact-arithmetic reference.
module tb_fp_to_int;
  logic        clk = 1'b0, areset = 1'b1, en = 1'b0, in_valid = 1'b0, is_signed = 1'b0, rnd = 1'b0;
  logic [31:0] a = 32'h0;
  logic        ov32, inv32, inx32, ov16, inv16, inx16;
  logic [31:0] q32;
  logic [15:0] q16;
  always #5 clk = ~clk;
  fp_to_int #(.OUT_WIDTH(32), .LATENCY(3)) dut32 (
    .clk(clk), .areset(areset), .en(en), .in_valid(in_valid), .a(a), .is_signed(is_signed),
    .rnd(rnd), .out_valid(ov32), .q(q32), .invalid(inv32), .inexact(inx32));
  fp_to_int #(.OUT_WIDTH(16), .LATENCY(1)) dut16 (
    .clk(clk), .areset(areset), .en(en), .in_valid(in_valid), .a(a), .is_signed(is_signed),
    .rnd(rnd), .out_valid(ov16), .q(q16), .invalid(inv16), .inexact(inx16));
  typedef struct { logic [63:0] q; logic inv; logic inx; int tag; } exp_t;
  exp_t        sb32[$], sb16[$];
  int          checks = 0, errors = 0, en_cnt = 0;
  bit          last_en = 1'b1, snap_ok = 1'b0;
  logic [34:0] snap32;
  logic [18:0] snap16;
  logic [31:0] sp [8] = '{32'h7F800000, 32'hFF800000, 32'h7FC00001, 32'hFFFFFFFF,
                          32'h80000001, 32'h4F000000, 32'hCF000001, 32'h46FFFE00};
  logic [31:0] da [16] = '{32'h3FC00000, 32'h3FC00000, 32'h40200000, 32'h4F800000,
                           32'hCF000000, 32'hBF800000, 32'h7FC00000, 32'h80000000,
                           32'h00000001, 32'h47000000, 32'h7F800000, 32'hFF800000,
                           32'hBECCCCCD, 32'h3F000000, 32'h3F400000, 32'hC7000000};
  bit          ds [16] = '{0, 0, 0, 0, 1, 0, 1, 1, 1, 1, 0, 1, 0, 0, 0, 1};
  bit          dr [16] = '{0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0};
  // Exact value of a scaled by 2^150 so every binary32 is an integer; no shift/guard datapath.
  function automatic logic [65:0] model(input logic [31:0] x, input bit sg, input bit rn, input int w);
    logic [7:0]          e;
    logic [301:0]        num, ip, rem, half;
    logic signed [301:0] val, hi, lo, mask, one;
    bit                  nan, inf, inv, inx;
    one  = 302'sd1;
    e    = x[30:23];
    nan  = (e == 8'hFF) && (x[22:0] != 0);
    inf  = (e == 8'hFF) && (x[22:0] == 0);
    num  = (e == 8'd0) ? (302'(x[22:0]) << 1) : (302'({1'b1, x[22:0]}) << e);
    ip   = num >> 150;
    rem  = num - (ip << 150);
    half = 302'(1) << 149;
    if (rn && ((rem > half) || ((rem == half) && ip[0]))) ip = ip + 302'(1);
    val  = x[31] ? -$signed(ip) : $signed(ip);
    hi   = sg ? (one <<< (w - 1)) - one : (one <<< w) - one;
    lo   = sg ? -(one <<< (w - 1)) : 302'sd0;
    mask = (one <<< w) - one;
    inv  = 1'b0;
    inx  = 1'b0;
    if (nan || (inf && !x[31])) begin val = hi; inv = 1'b1; end
    else if (inf) begin val = lo; inv = 1'b1; end
    else if (val > hi) begin val = hi; inv = 1'b1; end
    else if (val < lo) begin val = lo; inv = 1'b1; end
    else inx = (rem != 0);
    return {64'(val & mask), inv, inx};
  endfunction
  function automatic logic [31:0] rand_fp();
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return {1'($urandom), 8'($urandom_range(100, 200)), 23'($urandom)};
      2: return {1'($urandom), 8'($urandom_range(125, 160)), 23'($urandom) & 23'h7F0000};
      default: return sp[$urandom_range(0, 7)];
    endcase
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic check_outs();
    exp_t x;
    if (last_en) begin
      if (ov32) begin
        chk("pending32", 64'(sb32.size() != 0), 64'd1);
        if (sb32.size() != 0) begin
          x = sb32.pop_front();
          chk("q32", 64'(q32), x.q);
          chk("invalid32", 64'(inv32), 64'(x.inv));
          chk("inexact32", 64'(inx32), 64'(x.inx));
          chk("latency32", 64'(en_cnt - x.tag), 64'd2);
        end
      end
      if (ov16) begin
        chk("pending16", 64'(sb16.size() != 0), 64'd1);
        if (sb16.size() != 0) begin
          x = sb16.pop_front();
          chk("q16", 64'(q16), x.q);
          chk("invalid16", 64'(inv16), 64'(x.inv));
          chk("inexact16", 64'(inx16), 64'(x.inx));
          chk("latency16", 64'(en_cnt - x.tag), 64'd0);
        end
      end
    end else if (snap_ok) begin
      chk("hold32", 64'({ov32, q32, inv32, inx32}), 64'(snap32));
      chk("hold16", 64'({ov16, q16, inv16, inx16}), 64'(snap16));
    end
    snap32  = {ov32, q32, inv32, inx32};
    snap16  = {ov16, q16, inv16, inx16};
    snap_ok = 1'b1;
  endtask
  task automatic cycle();
    logic [65:0] r;
    @(posedge clk);
    last_en = en;
    if (en) begin
      en_cnt++;
      if (in_valid) begin
        r = model(a, is_signed, rnd, 32);
        sb32.push_back('{r[65:2], r[1], r[0], en_cnt});
        r = model(a, is_signed, rnd, 16);
        sb16.push_back('{r[65:2], r[1], r[0], en_cnt});
      end
    end
    @(negedge clk);
    check_outs();
  endtask
  task automatic req(input bit e, input bit v, input logic [31:0] x, input bit s, input bit r);
    en = e; in_valid = v; a = x; is_signed = s; rnd = r;
    cycle();
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "32"}, 64'({ov32, q32, inv32, inx32}), 64'd0);
    chk({tag, "16"}, 64'({ov16, q16, inv16, inx16}), 64'd0);
  endtask
  initial begin
    en = 1'b1; in_valid = 1'b1; a = 32'h3F800000;
    #12;
    check_zero("reset");
    @(negedge clk);
    areset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req(1'b1, 1'b0, $urandom, 1'($urandom), 1'($urandom));
      check_zero("idle");
    end
    for (int i = 0; i < 16; i++) req(1'b1, 1'b1, da[i], ds[i], dr[i]);
    for (int i = 0; i < 4; i++) req(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (i == 5) begin
        req(1'b0, 1'b1, rand_fp(), 1'($urandom), 1'($urandom));
        req(1'b0, 1'b1, rand_fp(), 1'($urandom), 1'($urandom));
      end
      req(1'b1, 1'b1, rand_fp(), 1'($urandom), 1'($urandom));
    end
    for (int i = 0; i < 4; i++) req(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("stall_drain32", 64'(sb32.size()), 64'd0);
    chk("stall_drain16", 64'(sb16.size()), 64'd0);
    for (int i = 0; i < 400; i++)
      req(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 3) != 0), rand_fp(), 1'($urandom), 1'($urandom));
    for (int i = 0; i < 3; i++) req(1'b1, 1'b1, rand_fp(), 1'($urandom), 1'($urandom));
    #2 areset = 1'b1;
    #1 check_zero("async_reset");
    sb32.delete();
    sb16.delete();
    snap_ok = 1'b0;
    #1 areset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req(1'b1, 1'b0, rand_fp(), 1'b0, 1'b0);
      chk("post_reset_valid32", 64'(ov32), 64'd0);
    end
    req(1'b1, 1'b1, 32'h3FC00000, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) req(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("final_drain32", 64'(sb32.size()), 64'd0);
    chk("final_drain16", 64'(sb16.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
